stencil_write_arbiter: RTL and testbench
========================================

Name: stencil_write_arbiter

Overview:
Write-side controller for the 32x32 12-bit stencil/colour buffer. It arbitrates pixel writes from two draw clients with round-robin fairness and runs a full-buffer clear sequence on request. It drives the buffer's write port (address, data, write-enable). The buffer's read port and scanout are outside this block.

Parameters:
DATA_WIDTH, 12, pixel word width (4:4:4 RGB)
X_WIDTH, 5, column coordinate width
Y_WIDTH, 5, row coordinate width
ADDR_WIDTH, X_WIDTH+Y_WIDTH, buffer address width (derived)

Ports:
clock  input  1  single clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
clear_req  input  1  start a full-buffer clear; sampled only in IDLE
clear_color  input  DATA_WIDTH  fill value, latched with clear_req
busy  output  1  high while the clear sequence runs
clear_done  output  1  one-cycle pulse with the final clear write
req0_valid  input  1  client 0 write request
req0_x / req0_y  input  X_WIDTH / Y_WIDTH  client 0 pixel coordinate
req0_data  input  DATA_WIDTH  client 0 pixel value
req0_ready  output  1  client 0 handshake accept
req1_valid, req1_x, req1_y, req1_data, req1_ready  as client 0, for client 1
mem_we  output  1  buffer write enable
mem_addr  output  ADDR_WIDTH  buffer write address = {y, x} (y in upper bits)
mem_data  output  DATA_WIDTH  buffer write data

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, clear counter=0, last-grant pointer=1 (so client 0 wins the first tie).
  - mem_we=0, mem_addr=0, mem_data=0, clear_done=0, busy=0.
  - Reset mid-clear aborts the clear; no further writes; no clear_done.
- mem_we, mem_addr, mem_data, clear_done and busy are registered. reqN_ready is combinational from state, the valids and the pointer.
- States:
  - IDLE -> CLEAR on clear_req=1.
  - CLEAR -> IDLE after the write to address (1<<ADDR_WIDTH)-1 is issued.
- IDLE arbitration:
  - Only one valid: that client's ready=1.
  - Both valid: grant the client other than the last-grant pointer.
  - Handshake = valid & ready. It updates the pointer to the granted client.
  - On the next edge: mem_we=1, mem_addr={y,x}, mem_data=data of the granted client. Write latency is 1 cycle after the handshake.
  - Throughput is 1 write per cycle. With both clients continuously valid, grants strictly alternate.
  - No handshake -> mem_we=0 next cycle; mem_addr/mem_data hold their values.
- Clear start:
  - clear_req=1 in IDLE has priority over client requests. Both readies are 0 that cycle and no client write occurs.
  - clear_color is latched, counter=0, state->CLEAR, busy=1 on that edge.
- CLEAR:
  - Both readies are 0.
  - Each edge: mem_we=1, mem_addr=counter, mem_data=latched colour, counter+1.
  - On the edge issuing the last address (1023 by default): clear_done=1, busy=0, state->IDLE.
  - Total: exactly 1<<ADDR_WIDTH consecutive writes.
- clear_req while in CLEAR is ignored, with no queuing. clear_color changes after the latch have no effect.
- clear_done is high for exactly one cycle. It coincides with the final clear write on the bus.
- Client handshakes may resume in the cycle where clear_done=1. The resulting write appears the following cycle, with no gap and no overlap.
- Coordinates are used unmodified. Address wrap is impossible because the widths match ADDR_WIDTH exactly.

Test Plan:
- Reset, then single client 0 write x=3,y=2,data=12'hF00 -> req0_ready=1 that cycle; next cycle mem_we=1, mem_addr=10'd67, mem_data=12'hF00; following cycle mem_we=0.
- Both valid for 4 cycles, client 0 data=12'h111, client 1 data=12'h222 -> grants in order 0,1,0,1; mem_data sequence 111,222,111,222 one cycle delayed; never two readies high in the same cycle.
- clear_req with clear_color=12'h0A5 -> busy=1 next cycle; 1024 consecutive writes with mem_addr 0..1023 and data 0A5; clear_done=1 only alongside addr 1023; then busy=0.
- clear_req and req0_valid in the same IDLE cycle -> req0_ready=0; clear runs; req0 is accepted in the clear_done cycle and written at the next edge with data intact.
- clear_req pulsed again at counter=500 with colour 12'hFFF -> ignored; all 1024 writes carry 0A5; exactly one clear_done.
- reset_n=0 at counter=300 -> next cycle mem_we=0, busy=0, clear_done=0; a new clear_req after release restarts at address 0.

Source files
------------

// File: rtl/stencil_write_arbiter.sv
// Write-port controller for the stencil/colour buffer: round-robin arbitration
// between two draw clients plus a full-buffer clear sequence.
module stencil_write_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 5,
  parameter int Y_WIDTH    = 5,
  parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  busy,
  output logic                  clear_done,
  input  logic                  req0_valid,
  input  logic [X_WIDTH-1:0]    req0_x,
  input  logic [Y_WIDTH-1:0]    req0_y,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [X_WIDTH-1:0]    req1_x,
  input  logic [Y_WIDTH-1:0]    req1_y,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  state_dbg
);

  // Handshake: a client write is accepted in a cycle where reqN_valid and
  // reqN_ready are both high; ready never depends on the accepted data and at
  // most one ready is high per cycle. The write reaches the bus one edge later.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   color_q, color_d;
  logic                    last_q, last_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    grant0, grant1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      last_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      last_q     <= last_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    last_d     = last_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    grant0     = 1'b0;
    grant1     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          color_d = clear_color;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          // last_q = 1 means client 1 was served most recently
          grant0 = req0_valid && (!req1_valid || last_q);
          grant1 = req1_valid && (!req0_valid || !last_q);
          if (grant0) begin
            mem_we_d   = 1'b1;
            mem_addr_d = {req0_y, req0_x};
            mem_data_d = req0_data;
            last_d     = 1'b0;
          end else if (grant1) begin
            mem_we_d   = 1'b1;
            mem_addr_d = {req1_y, req1_x};
            mem_data_d = req1_data;
            last_d     = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = cnt_q;
        mem_data_d = color_q;
        cnt_d      = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign clear_done = done_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stencil_write_arbiter.sv
// Scoreboard bench for stencil_write_arbiter: a reference model predicts
// readies, busy and every bus write; a monitor checks the bus each cycle.
module tb_stencil_write_arbiter;

  localparam int DW = 12;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int AW = XW + YW;
  localparam int NWORDS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          busy, clear_done;
  logic          req0_valid, req1_valid;
  logic [XW-1:0] req0_x, req1_x;
  logic [YW-1:0] req0_y, req1_y;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          state_dbg;

  stencil_write_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {clear_done, addr, data}, paired with the cycle it is due
  logic [AW+DW:0] exp_q[$];
  int             exp_cyc_q[$];
  int             exp_reset_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // reference model: operates on the buffer as a list of pixel writes
  bit            m_clearing = 0;
  int            m_idx = 0;
  logic [DW-1:0] m_color = '0;
  int            m_last = 1;

  always @(negedge clock) begin
    int  g;
    int  a;
    logic [DW-1:0] d;
    if (!reset_n) begin
      m_clearing = 0;
      m_idx = 0;
      m_last = 1;
      exp_q.delete();
      exp_cyc_q.delete();
      exp_reset_cyc = cyc + 1;
    end else begin
      g = -1;
      check("busy", {31'd0, busy}, {31'd0, m_clearing});
      if (m_clearing) begin
        exp_q.push_back({(m_idx == NWORDS - 1), m_idx[AW-1:0], m_color});
        exp_cyc_q.push_back(cyc + 1);
        if (m_idx == NWORDS - 1) m_clearing = 0;
        else m_idx++;
      end else if (clear_req) begin
        m_clearing = 1;
        m_idx = 0;
        m_color = clear_color;
      end else begin
        if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        if (g >= 0) begin
          a = (g == 0) ? (int'(req0_y) * (1 << XW) + int'(req0_x))
                       : (int'(req1_y) * (1 << XW) + int'(req1_x));
          d = (g == 0) ? req0_data : req1_data;
          exp_q.push_back({1'b0, a[AW-1:0], d});
          exp_cyc_q.push_back(cyc + 1);
          m_last = g;
        end
      end
      check("req0_ready", {31'd0, req0_ready}, {31'd0, (g == 0)});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, (g == 1)});
      check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
    end
  end

  // monitor: compares the write port against the expected queue every cycle
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  always @(posedge clock) begin
    logic [AW+DW:0] e;
    #2;
    if (exp_reset_cyc >= 0 && cyc >= exp_reset_cyc) begin
      if (cyc == exp_reset_cyc) begin
        last_a = '0;
        last_d = '0;
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("mem_we", {31'd0, mem_we}, 32'd1);
        check("mem_addr", {22'd0, mem_addr}, {22'd0, e[AW+DW-1:DW]});
        check("mem_data", {20'd0, mem_data}, {20'd0, e[DW-1:0]});
        check("clear_done", {31'd0, clear_done}, {31'd0, e[AW+DW]});
        last_a = e[AW+DW-1:DW];
        last_d = e[DW-1:0];
      end else begin
        check("mem_we_idle", {31'd0, mem_we}, 32'd0);
        check("clear_done_idle", {31'd0, clear_done}, 32'd0);
        check("mem_addr_hold", {22'd0, mem_addr}, {22'd0, last_a});
        check("mem_data_hold", {20'd0, mem_data}, {20'd0, last_d});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 0;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_hs0(input int budget);
    bit hs;
    hs = 0;
    for (int i = 0; i < budget && !hs; i++) begin
      @(negedge clock);
      hs = req0_ready;
      tick();
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL req0_accept_timeout cyc=%0d actual=no_handshake expected=handshake", cyc);
    end
  endtask

  initial begin
    reset_n = 0;
    clear_req = 0;
    clear_color = '0;
    req0_valid = 0; req0_x = '0; req0_y = '0; req0_data = '0;
    req1_valid = 0; req1_x = '0; req1_y = '0; req1_data = '0;
    repeat (3) tick();
    reset_n = 1;
    tick();

    // single client 0 write: (3,2) -> address 67
    req0_valid = 1; req0_x = 5'd3; req0_y = 5'd2; req0_data = 12'hF00;
    tick();
    idle_inputs();
    repeat (2) tick();

    // both clients continuously valid: grants alternate 0,1,0,1
    req0_valid = 1; req0_x = 5'd1; req0_y = 5'd1; req0_data = 12'h111;
    req1_valid = 1; req1_x = 5'd4; req1_y = 5'd6; req1_data = 12'h222;
    repeat (4) tick();
    idle_inputs();
    tick();

    // clear collides with a client request; second clear_req mid-sequence ignored
    clear_req = 1; clear_color = 12'h0A5;
    req0_valid = 1; req0_x = 5'd7; req0_y = 5'd9; req0_data = 12'hABC;
    tick();
    clear_req = 0; clear_color = 12'h123;
    repeat (500) tick();
    clear_req = 1; clear_color = 12'hFFF;
    tick();
    clear_req = 0;
    wait_hs0(2000);
    idle_inputs();
    repeat (2) tick();

    // reset mid-clear, then a fresh clear from address 0
    clear_req = 1; clear_color = 12'h3C3;
    tick();
    clear_req = 0;
    repeat (300) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    clear_req = 1; clear_color = 12'h5A5;
    tick();
    clear_req = 0;
    repeat (NWORDS + 4) tick();

    // randomized traffic with occasional clears
    for (int i = 0; i < 800; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_x = 5'($urandom_range(0, 31));
      req0_y = 5'($urandom_range(0, 31));
      req1_x = 5'($urandom_range(0, 31));
      req1_y = 5'($urandom_range(0, 31));
      req0_data = 12'($urandom);
      req1_data = 12'($urandom);
      clear_color = 12'($urandom);
      clear_req = ($urandom_range(0, 399) == 0);
      tick();
    end
    idle_inputs();
    repeat (NWORDS + 8) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes actual=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
